pipe_stage_fifo: RTL and testbench

// - Parametrised inter-stage pipeline buffer; next generation of the single-entry stage registers

---
 rtl/pipe_stage_fifo_if.sv | 28 ++
 rtl/pipe_stage_fifo.sv | 101 ++++++++++
 tb/tb_pipe_stage_fifo.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_fifo_if.sv
// Handshake and status bundle between a pipe_stage_fifo and its neighbouring stages.
// The FIFO sits on the slave modport; the upstream/downstream logic drives the master side.
interface pipe_stage_fifo_if #(
  parameter int PAYLOAD_W = 138,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 32
);
  logic                         in_valid;
  logic                         in_bubble;
  logic [PAYLOAD_W-1:0]         in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [PAYLOAD_W-1:0]         out_data;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic [CNT_W-1:0]             perf_stall;
  logic [CNT_W-1:0]             perf_flush;

  modport master (
    output in_valid, in_bubble, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, perf_stall, perf_flush
  );

  modport slave (
    input  in_valid, in_bubble, in_data, out_ready,
    output in_ready, out_valid, out_data, count, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipe_stage_fifo.sv
// DEPTH-entry inter-stage pipeline buffer with flush, bubble insert and global freeze (rdy).
// Optional stall/flush perf counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_fifo #(
  parameter int                   PAYLOAD_W   = 138,
  parameter int                   DEPTH       = 2,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
  parameter int                   CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             flush,
  pipe_stage_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full, empty, enq, deq;
  logic [PAYLOAD_W-1:0] wr_payload;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign enq        = rdy & bus.in_valid & ~full & ~flush;
  assign deq        = rdy & ~empty & bus.out_ready & ~flush;
  assign wr_payload = bus.in_bubble ? NOP_PAYLOAD : bus.in_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted as valid.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= wr_payload;
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? NOP_PAYLOAD : mem_q[rd_ptr_q];
  assign bus.count     = count_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters stop at all-ones rather than wrapping.
  always_comb begin
    stall_d     = stall_q;
    flush_cnt_d = flush_cnt_q;
    if (rdy) begin
      if (bus.in_valid && full && !flush && !(&stall_q)) stall_d = stall_q + 1'b1;
      if (flush && !empty && !(&flush_cnt_q))            flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_q     <= stall_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.perf_stall = stall_q;
  assign bus.perf_flush = flush_cnt_q;
`else
  assign bus.perf_stall = '0;
  assign bus.perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: DEPTH=2 and DEPTH=4 instances share one stimulus stream and are
// each compared every cycle against a queue-based reference model.
module tb_pipe_stage_fifo;

  localparam int PW  = 138;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [PW-1:0] NOP = {10'h155, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D};

  typedef logic [PW-1:0] pl_t;

  logic clk = 1'b0;
  logic rst_n, rdy, flush, in_valid, in_bubble, out_ready;
  pl_t  in_data;

  always #5 clk = ~clk;

  pipe_stage_fifo_if #(.PAYLOAD_W(PW), .DEPTH(2), .CNT_W(CW)) bus2 ();
  pipe_stage_fifo_if #(.PAYLOAD_W(PW), .DEPTH(4), .CNT_W(CW)) bus4 ();

  assign bus2.in_valid  = in_valid;
  assign bus2.in_bubble = in_bubble;
  assign bus2.in_data   = in_data;
  assign bus2.out_ready = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_bubble = in_bubble;
  assign bus4.in_data   = in_data;
  assign bus4.out_ready = out_ready;

  pipe_stage_fifo #(.PAYLOAD_W(PW), .DEPTH(2), .NOP_PAYLOAD(NOP), .CNT_W(CW)) dut2 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .bus(bus2.slave));
  pipe_stage_fifo #(.PAYLOAD_W(PW), .DEPTH(4), .NOP_PAYLOAD(NOP), .CNT_W(CW)) dut4 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .bus(bus4.slave));

  // Reference model: one queue per instance plus plain perf tallies.
  pl_t q2[$];
  pl_t q4[$];
  int  ps[2];
  int  pf[2];
  bit  acc2;
  int  vectors = 0;
  int  miscompares = 0;

  function automatic int mcap(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int msize(int k);
    return (k == 0) ? q2.size() : q4.size();
  endfunction

  function automatic pl_t mhead(int k);
    return (k == 0) ? q2[0] : q4[0];
  endfunction

  function automatic void mpush(int k, pl_t v);
    if (k == 0) q2.push_back(v);
    else        q4.push_back(v);
  endfunction

  function automatic void mpop(int k);
    if (k == 0) q2.delete(0);
    else        q4.delete(0);
  endfunction

  function automatic void mclear(int k);
    if (k == 0) q2.delete();
    else        q4.delete();
  endfunction

  function automatic pl_t rand_pl();
    pl_t v = '0;
    for (int i = 0; i < 5; i++) v = {v[PW-33:0], $urandom()};
    return v;
  endfunction

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      int cap = mcap(k);
      int sz  = msize(k);
      if (!rst_n) begin
        mclear(k);
        ps[k] = 0;
        pf[k] = 0;
      end else if (rdy) begin
        if (flush) begin
          if (sz != 0 && pf[k] < SAT) pf[k]++;
          mclear(k);
        end else begin
          if (in_valid && sz == cap && ps[k] < SAT) ps[k]++;
          if (out_ready && sz > 0) mpop(k);
          if (in_valid && sz < cap) begin
            mpush(k, in_bubble ? NOP : in_data);
            if (k == 0) acc2 = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    for (int k = 0; k < 2; k++) begin
      int  sz  = msize(k);
      int  cap = mcap(k);
      pl_t exp_data = (sz != 0) ? mhead(k) : NOP;
      int  exp_ps = 0;
      int  exp_pf = 0;
`ifdef PIPE_STAGE_PERF_EN
      exp_ps = ps[k];
      exp_pf = pf[k];
`endif
      if (k == 0) begin
        chk($sformatf("%s d2 out_valid", ph), 256'(bus2.out_valid), 256'(sz != 0));
        chk($sformatf("%s d2 in_ready", ph),  256'(bus2.in_ready),  256'(sz < cap));
        chk($sformatf("%s d2 count", ph),     256'(bus2.count),     256'(sz));
        chk($sformatf("%s d2 out_data", ph),  256'(bus2.out_data),  256'(exp_data));
        chk($sformatf("%s d2 perf_stall", ph), 256'(bus2.perf_stall), 256'(exp_ps));
        chk($sformatf("%s d2 perf_flush", ph), 256'(bus2.perf_flush), 256'(exp_pf));
      end else begin
        chk($sformatf("%s d4 out_valid", ph), 256'(bus4.out_valid), 256'(sz != 0));
        chk($sformatf("%s d4 in_ready", ph),  256'(bus4.in_ready),  256'(sz < cap));
        chk($sformatf("%s d4 count", ph),     256'(bus4.count),     256'(sz));
        chk($sformatf("%s d4 out_data", ph),  256'(bus4.out_data),  256'(exp_data));
        chk($sformatf("%s d4 perf_stall", ph), 256'(bus4.perf_stall), 256'(exp_ps));
        chk($sformatf("%s d4 perf_flush", ph), 256'(bus4.perf_flush), 256'(exp_pf));
      end
    end
  endtask

  task automatic step(string ph);
    @(posedge clk);
    model_clock();
    #1;
    check_all(ph);
  endtask

  initial begin
    pl_t a, b, c;

    // Reset with everything else active, including rdy=0 and flush, to prove its priority.
    rst_n = 1'b0; rdy = 1'b0; flush = 1'b1; in_valid = 1'b1; in_bubble = 1'b0;
    out_ready = 1'b1; in_data = rand_pl();
    step("reset");
    rdy = 1'b1;
    step("reset");
    chk("reset d2 out_data nop", 256'(bus2.out_data), 256'(NOP));
    chk("reset d2 in_ready", 256'(bus2.in_ready), 256'(1));

    // Streaming through DEPTH=2 at full rate.
    rst_n = 1'b1; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = rand_pl();
      in_data = a;
      step("stream");
      chk("stream d2 count one", 256'(bus2.count), 256'(1));
      chk("stream d2 head", 256'(bus2.out_data), 256'(a));
    end
    in_valid = 1'b0;
    step("stream drain");

    // Backpressure: fill, hold C until the DEPTH=2 instance takes it.
    out_ready = 1'b0; in_valid = 1'b1;
    a = rand_pl(); in_data = a; step("bp fill");
    b = rand_pl(); in_data = b; step("bp fill");
    chk("bp d2 full count", 256'(bus2.count), 256'(2));
    chk("bp d2 full in_ready", 256'(bus2.in_ready), 256'(0));
    c = rand_pl(); in_data = c;
    step("bp hold");
    out_ready = 1'b1;
    acc2 = 1'b0;
    for (int i = 0; i < 10 && !acc2; i++) step("bp release");
    chk("bp d2 C accepted within bound", 256'(acc2), 256'(1));
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step("bp drain");

    // Flush with simultaneous enq/deq attempts.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = rand_pl(); step("flush fill");
    in_data = rand_pl(); step("flush fill");
    flush = 1'b1; out_ready = 1'b1; in_data = rand_pl();
    step("flush");
    chk("flush d2 count", 256'(bus2.count), 256'(0));
    chk("flush d2 out_valid", 256'(bus2.out_valid), 256'(0));
    flush = 1'b0; in_valid = 1'b0;
    step("flush after");

    // Bubble insert, then in_bubble without in_valid.
    out_ready = 1'b0; in_valid = 1'b1; in_bubble = 1'b1; in_data = '1;
    step("bubble");
    chk("bubble d2 valid", 256'(bus2.out_valid), 256'(1));
    chk("bubble d2 nop", 256'(bus2.out_data), 256'(NOP));
    in_valid = 1'b0;
    step("bubble idle");
    in_bubble = 1'b0; out_ready = 1'b1;
    step("bubble drain");
    step("bubble drain");

    // Freeze: rdy low ignores handshakes and flush.
    out_ready = 1'b0; in_valid = 1'b1; in_data = rand_pl();
    step("freeze fill");
    rdy = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = i[0];
      in_data = rand_pl();
      step("freeze");
      chk("freeze d2 count", 256'(bus2.count), 256'(1));
    end
    rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("freeze drain");

    // Pointer wrap in DEPTH=4 via 10 back-to-back pairs.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = rand_pl();
      step("wrap");
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("wrap drain");

    // Stall counting from a fresh reset: fill DEPTH=4, then hold 5 cycles.
    rst_n = 1'b0; step("perf reset");
    rst_n = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = rand_pl();
      step("perf stall");
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("perf d4 stall five", 256'(bus4.perf_stall), 256'(5));
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step("perf drain");

    // Randomised traffic; long enough for perf counters to hit saturation.
    for (int i = 0; i < 400; i++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bubble = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      in_data   = rand_pl();
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
